// File: rtl/register_scoreboard.sv
// Per-register pending-write scoreboard for an in-order pipeline: tracks outstanding
// writes per register and raises a stall for RAW hazards or a load-use bubble.
module register_scoreboard (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_en,
    input  logic        issue_wb_en,
    input  logic        issue_mem_r_en,
    input  logic [3:0]  issue_dest,
    input  logic [3:0]  src1,
    input  logic [3:0]  src2,
    input  logic        two_src,
    input  logic        forward_en,
    input  logic        retire_en,
    input  logic [3:0]  retire_dest,
    input  logic        flush,
    output logic        hazard_detected,
    output logic [15:0] busy_mask,
    output logic        sb_err
);

    logic [15:0][1:0] cnt_q, cnt_d;
    logic             ld_valid_q, ld_valid_d;
    logic [3:0]       ld_dest_q, ld_dest_d;
    logic             err_q, err_d;

    logic             issue_acc;
    logic [15:0]      inc_vec;
    logic [15:0]      dec_vec;

    // Stall is derived from registered state only, so a retire in WB releases it a cycle later.
    always_comb begin
        if (forward_en) begin
            hazard_detected = ld_valid_q &
                              ((src1 == ld_dest_q) | (two_src & (src2 == ld_dest_q)));
        end else begin
            hazard_detected = busy_mask[src1] | (two_src & busy_mask[src2]);
        end
    end

    assign issue_acc = issue_en & issue_wb_en & ~hazard_detected;
    assign inc_vec   = issue_acc ? (16'h0001 << issue_dest) : 16'h0000;
    assign dec_vec   = retire_en ? (16'h0001 << retire_dest) : 16'h0000;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        for (int r = 0; r < 16; r++) begin
            if (flush) begin
                cnt_d[r] = 2'd0;
            end else if (inc_vec[r] && !dec_vec[r]) begin
                if (cnt_q[r] == 2'd3) err_d = 1'b1;
                else                  cnt_d[r] = cnt_q[r] + 2'd1;
            end else if (dec_vec[r] && !inc_vec[r]) begin
                if (cnt_q[r] == 2'd0) err_d = 1'b1;
                else                  cnt_d[r] = cnt_q[r] - 2'd1;
            end
        end
    end

    always_comb begin
        ld_valid_d = flush ? 1'b0 : (issue_acc & issue_mem_r_en);
        ld_dest_d  = issue_dest;
    end

    always_comb begin
        busy_mask = 16'h0000;
        for (int r = 0; r < 16; r++) begin
            busy_mask[r] = |cnt_q[r];
        end
    end

    assign sb_err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            ld_valid_q <= 1'b0;
            ld_dest_q  <= 4'd0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ld_valid_q <= ld_valid_d;
            ld_dest_q  <= ld_dest_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard: hazard stall/release, saturation,
// load-use bubble, flush priority and asynchronous reset.
module tb_register_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        issue_en;
    logic        issue_wb_en;
    logic        issue_mem_r_en;
    logic [3:0]  issue_dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        two_src;
    logic        forward_en;
    logic        retire_en;
    logic [3:0]  retire_dest;
    logic        flush;
    logic        hazard_detected;
    logic [15:0] busy_mask;
    logic        sb_err;

    int n_assert;
    int n_fail;

    register_scoreboard dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .issue_en        (issue_en),
        .issue_wb_en     (issue_wb_en),
        .issue_mem_r_en  (issue_mem_r_en),
        .issue_dest      (issue_dest),
        .src1            (src1),
        .src2            (src2),
        .two_src         (two_src),
        .forward_en      (forward_en),
        .retire_en       (retire_en),
        .retire_dest     (retire_dest),
        .flush           (flush),
        .hazard_detected (hazard_detected),
        .busy_mask       (busy_mask),
        .sb_err          (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_en = 0; issue_wb_en = 0; issue_mem_r_en = 0; issue_dest = 0;
        retire_en = 0; retire_dest = 0; flush = 0;
    endtask

    task automatic issue(input logic [3:0] d, input logic ld);
        issue_en = 1; issue_wb_en = 1; issue_mem_r_en = ld; issue_dest = d;
    endtask

    task automatic retire(input logic [3:0] d);
        retire_en = 1; retire_dest = d;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        idle();
        src1 = 0; src2 = 0; two_src = 0; forward_en = 0;
        rst_n = 0;
        #1;
        chk("reset_busy", busy_mask, 16'h0000);
        chk("reset_hazard", {15'd0, hazard_detected}, 16'd0);
        chk("reset_err", {15'd0, sb_err}, 16'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;

        // RAW stall on R3, released one cycle after its retire
        tick(); issue(4'd3, 0);
        tick(); idle(); src1 = 4'd3; #1;
        chk("raw_busy", busy_mask, 16'h0008);
        chk("raw_hazard", {15'd0, hazard_detected}, 16'd1);
        retire(4'd3); #1;
        chk("raw_hazard_during_retire", {15'd0, hazard_detected}, 16'd1);
        tick(); idle(); #1;
        chk("raw_busy_released", busy_mask, 16'h0000);
        chk("raw_hazard_released", {15'd0, hazard_detected}, 16'd0);
        src1 = 0;

        // Load-use bubble with forwarding
        forward_en = 1;
        issue(4'd2, 1);
        tick(); idle(); src2 = 4'd2; two_src = 1; #1;
        chk("lu_two_src_hazard", {15'd0, hazard_detected}, 16'd1);
        tick(); #1;
        chk("lu_one_cycle_only", {15'd0, hazard_detected}, 16'd0);
        issue(4'd2, 1);
        tick(); idle(); two_src = 0; #1;
        chk("lu_src2_ignored", {15'd0, hazard_detected}, 16'd0);
        src1 = 4'd2; issue(4'd10, 0); #1;
        chk("lu_src1_hazard", {15'd0, hazard_detected}, 16'd1);
        tick(); idle(); #1;
        chk("stalled_issue_dropped", busy_mask, 16'h0004);
        chk("ld_valid_cleared", {15'd0, hazard_detected}, 16'd0);
        src1 = 0; src2 = 0; forward_en = 0;
        retire(4'd2);
        tick(); tick(); idle(); #1;
        chk("r2_drained", busy_mask, 16'h0000);

        // Same-cycle issue and retire of R7
        issue(4'd7, 0);
        tick(); #1;
        chk("r7_busy", busy_mask, 16'h0080);
        retire(4'd7);
        tick(); idle(); #1;
        chk("r7_same_cycle", busy_mask, 16'h0080);
        retire(4'd7);
        tick(); idle(); #1;
        chk("r7_drained", busy_mask, 16'h0000);
        chk("r7_no_err", {15'd0, sb_err}, 16'd0);

        // Flush wins over a simultaneous load issue
        issue(4'd1, 0); tick();
        issue(4'd4, 0); tick();
        issue(4'd6, 1); tick(); idle(); #1;
        chk("pre_flush_busy", busy_mask, 16'h0052);
        flush = 1; issue(4'd8, 1);
        tick(); idle(); #1;
        chk("flush_busy", busy_mask, 16'h0000);
        chk("flush_hazard", {15'd0, hazard_detected}, 16'd0);
        forward_en = 1; src1 = 4'd8; #1;
        chk("flush_ld_valid", {15'd0, hazard_detected}, 16'd0);
        forward_en = 0; src1 = 0;
        retire(4'd9);
        tick(); idle(); #1;
        chk("underflow_err", {15'd0, sb_err}, 16'd1);
        chk("underflow_busy", busy_mask, 16'h0000);

        // Asynchronous reset between edges
        issue(4'd1, 0); tick();
        issue(4'd4, 0); tick(); idle(); #1;
        chk("pre_reset_busy", busy_mask, 16'h0012);
        src1 = 4'd1; #1;
        chk("pre_reset_hazard", {15'd0, hazard_detected}, 16'd1);
        rst_n = 0; #1;
        chk("async_busy", busy_mask, 16'h0000);
        chk("async_err", {15'd0, sb_err}, 16'd0);
        chk("async_hazard", {15'd0, hazard_detected}, 16'd0);
        src1 = 0;
        @(negedge clk); rst_n = 1;

        // Saturation of R5
        tick();
        issue(4'd5, 0); tick(); tick(); tick(); #1;
        chk("sat_busy", busy_mask, 16'h0020);
        chk("sat_no_err_yet", {15'd0, sb_err}, 16'd0);
        tick(); idle(); #1;
        chk("overflow_err", {15'd0, sb_err}, 16'd1);
        retire(4'd5); tick(); tick(); #1;
        chk("sat_still_busy", busy_mask, 16'h0020);
        tick(); idle(); #1;
        chk("sat_drained", busy_mask, 16'h0000);
        chk("err_sticky", {15'd0, sb_err}, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
